// File: rtl/dac_frame_tx_if.sv
// Packed sample bus from the output preprocessor into dac_frame_tx.
// Handshake: data_valid is a one-cycle strobe with no ready; the transmitter
// never back-pressures the producer. A set offered while a sweep is running is
// held one deep (latest wins) and an overwritten set is flagged as overrun.
interface dac_frame_tx_if #(
    parameter int W_CHAN = 16,
    parameter int N_CHAN = 8
);
    logic [W_CHAN*N_CHAN-1:0] data_packed;
    logic [N_CHAN-1:0]        chan_active;
    logic                     data_valid;

    modport master (output data_packed, output chan_active, output data_valid);
    modport slave  (input  data_packed, input  chan_active, input  data_valid);
endinterface

// File: rtl/dac_frame_tx.sv
// dac_frame_tx: snapshots the packed channel bus on a strobe and shifts one
// 32-bit write-and-update frame per active channel to a DAC8568-style serial DAC
// (SYNC/SCLK/DIN, MSB first, DAC samples on SCLK falling edge).
// Optional build macro DAC_INIT_EN: after every reset an INIT state sends one
// internal-reference-on frame before the first sweep.
// The input bus is registered once, so a strobe seen at edge 0 reaches LOAD at
// edge 1 and the first SCLK high at edge 2. All pins come straight from flops.
module dac_frame_tx #(
    parameter int W_CHAN  = 16,
    parameter int N_CHAN  = 8,
    parameter int W_ADDR  = 4,
    parameter int CLK_DIV = 2
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    dac_frame_tx_if.slave     bus,
    output logic              dac_sync_n_out,
    output logic              dac_sclk_out,
    output logic              dac_din_out,
    output logic              busy_out,
    output logic              frame_done_out,
    output logic [W_ADDR-1:0] chan_addr_out,
    output logic              sweep_done_out,
    output logic              overrun_out,
    output logic [2:0]        dbg_state
);
    localparam int FW    = 12 + W_ADDR + W_CHAN;
    localparam int W_CNT = $clog2(2 * CLK_DIV + 1);
    localparam int W_BIT = $clog2(FW + 1);
    localparam int W_BUS = W_CHAN * N_CHAN;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_GAP   = 3'd3
`ifdef DAC_INIT_EN
        , S_INIT = 3'd4
`endif
    } state_t;

`ifdef DAC_INIT_EN
    localparam state_t        S_RESET       = S_INIT;
    localparam logic          INIT_AT_RESET = 1'b1;
    localparam logic [FW-1:0] INIT_FRAME    = {8'h08, {(FW - 9){1'b0}}, 1'b1};
`else
    localparam state_t        S_RESET       = S_IDLE;
    localparam logic          INIT_AT_RESET = 1'b0;
`endif

    state_t              state_q, state_d;
    logic [W_CNT-1:0]    cnt_q, cnt_d;
    logic [W_BIT-1:0]    bit_cnt_q, bit_cnt_d;
    logic [FW-1:0]       shreg_q, shreg_d;
    logic                sync_n_q, sync_n_d;
    logic                sclk_q, sclk_d;
    logic                din_q, din_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;
    logic                sweep_done_q, sweep_done_d;
    logic                overrun_q, overrun_d;
    logic [W_ADDR-1:0]   chan_addr_q, chan_addr_d;
    logic [W_ADDR-1:0]   cur_addr_q, cur_addr_d;
    logic [W_BUS-1:0]    work_data_q, work_data_d;
    logic [N_CHAN-1:0]   work_mask_q, work_mask_d;
    logic                pend_valid_q, pend_valid_d;
    logic [W_BUS-1:0]    pend_data_q, pend_data_d;
    logic [N_CHAN-1:0]   pend_mask_q, pend_mask_d;
    logic                in_init_q, in_init_d;
    logic                dv_q;
    logic [W_BUS-1:0]    in_data_q;
    logic [N_CHAN-1:0]   in_mask_q;

    logic                strobe;
    logic                start;
    logic [FW-1:0]       load_word;
    logic [W_ADDR-1:0]   sel;
    logic [W_CHAN-1:0]   chan_data;
    logic [N_CHAN-1:0]   low_oh;

    // Register the input bus so the snapshot is taken on the strobe cycle itself.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            dv_q      <= 1'b0;
            in_data_q <= '0;
            in_mask_q <= '0;
        end else begin
            dv_q      <= bus.data_valid;
            in_data_q <= bus.data_packed;
            in_mask_q <= bus.chan_active;
        end
    end

    // State and datapath registers; reset forces the pins idle at once.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= S_RESET;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            sync_n_q     <= 1'b1;
            sclk_q       <= 1'b0;
            din_q        <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            sweep_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            chan_addr_q  <= '0;
            cur_addr_q   <= '0;
            work_data_q  <= '0;
            work_mask_q  <= '0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            pend_mask_q  <= '0;
            in_init_q    <= INIT_AT_RESET;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            sync_n_q     <= sync_n_d;
            sclk_q       <= sclk_d;
            din_q        <= din_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            sweep_done_q <= sweep_done_d;
            overrun_q    <= overrun_d;
            chan_addr_q  <= chan_addr_d;
            cur_addr_q   <= cur_addr_d;
            work_data_q  <= work_data_d;
            work_mask_q  <= work_mask_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            pend_mask_q  <= pend_mask_d;
            in_init_q    <= in_init_d;
        end
    end

    // Next-state, serializer and status-pulse logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        sync_n_d     = sync_n_q;
        sclk_d       = sclk_q;
        din_d        = din_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        sweep_done_d = 1'b0;
        overrun_d    = 1'b0;
        chan_addr_d  = chan_addr_q;
        cur_addr_d   = cur_addr_q;
        work_data_d  = work_data_q;
        work_mask_d  = work_mask_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        pend_mask_d  = pend_mask_q;
        in_init_d    = in_init_q;
        start        = 1'b0;
        load_word    = '0;
        sel          = '0;
        chan_data    = '0;

        // Lowest-index remaining channel wins; scan downwards so the last hit is the lowest.
        for (int i = N_CHAN - 1; i >= 0; i--) begin
            if (work_mask_q[i]) begin
                sel       = W_ADDR'(i);
                chan_data = work_data_q[i*W_CHAN +: W_CHAN];
            end
        end
        low_oh = work_mask_q & (~work_mask_q + N_CHAN'(1));

        // An all-zero mask carries no work and is dropped everywhere.
        strobe = dv_q && (in_mask_q != '0);

        // Any strobe outside IDLE (including the last GAP cycle) goes to the pending slot.
        if (strobe && (state_q != S_IDLE)) begin
            pend_valid_d = 1'b1;
            pend_data_d  = in_data_q;
            pend_mask_d  = in_mask_q;
            overrun_d    = pend_valid_q;
        end

        case (state_q)
            S_IDLE: begin
                if (strobe) begin
                    work_data_d = in_data_q;
                    work_mask_d = in_mask_q;
                    busy_d      = 1'b1;
                    state_d     = S_LOAD;
                end
            end
`ifdef DAC_INIT_EN
            S_INIT: begin
                start     = 1'b1;
                load_word = INIT_FRAME;
            end
`endif
            S_LOAD: begin
                start       = 1'b1;
                load_word   = {4'b0000, 4'b0011, sel, chan_data, 4'b0000};
                work_mask_d = work_mask_q & ~low_oh;
                cur_addr_d  = sel;
            end
            S_SHIFT: begin
                if (cnt_q == W_CNT'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                    end else if (bit_cnt_q == W_BIT'(FW - 1)) begin
                        state_d      = S_GAP;
                        sync_n_d     = 1'b1;
                        din_d        = 1'b0;
                        frame_done_d = !in_init_q;
                        if (!in_init_q) begin
                            chan_addr_d = cur_addr_q;
                        end
                    end else begin
                        sclk_d    = 1'b1;
                        din_d     = shreg_q[FW-1];
                        shreg_d   = {shreg_q[FW-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + W_BIT'(1);
                    end
                end else begin
                    cnt_d = cnt_q + W_CNT'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == W_CNT'(2 * CLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (work_mask_q != '0) begin
                        state_d = S_LOAD;
                    end else begin
                        sweep_done_d = !in_init_q;
                        in_init_d    = 1'b0;
                        if (pend_valid_d) begin
                            work_data_d  = pend_data_d;
                            work_mask_d  = pend_mask_d;
                            pend_valid_d = 1'b0;
                            state_d      = S_LOAD;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = S_IDLE;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + W_CNT'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Frame start: SYNC low, first SCLK high with the MSB already on DIN.
        if (start) begin
            state_d   = S_SHIFT;
            sync_n_d  = 1'b0;
            sclk_d    = 1'b1;
            din_d     = load_word[FW-1];
            shreg_d   = {load_word[FW-2:0], 1'b0};
            cnt_d     = '0;
            bit_cnt_d = '0;
            busy_d    = 1'b1;
        end
    end

    assign dac_sync_n_out = sync_n_q;
    assign dac_sclk_out   = sclk_q;
    assign dac_din_out    = din_q;
    assign busy_out       = busy_q;
    assign frame_done_out = frame_done_q;
    assign chan_addr_out  = chan_addr_q;
    assign sweep_done_out = sweep_done_q;
    assign overrun_out    = overrun_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_dac_frame_tx.sv
// Directed bench for dac_frame_tx: frames are rebuilt from DIN on SCLK falling
// edges and compared against hand-computed words, along with pulse counts,
// SYNC-low length and busy duration.
`timescale 1ns/1ps
module tb_dac_frame_tx;
    localparam int W_CHAN = 16;
    localparam int N_CHAN = 8;
    localparam int W_ADDR = 4;
    localparam int W_BUS  = W_CHAN * N_CHAN;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;
    always #5 clk_in = ~clk_in;

    dac_frame_tx_if #(.W_CHAN(W_CHAN), .N_CHAN(N_CHAN)) bus_if ();

    logic              dac_sync_n, dac_sclk, dac_din, busy, frame_done, sweep_done, overrun;
    logic [W_ADDR-1:0] chan_addr;
    logic [2:0]        dbg_state;

    dac_frame_tx #(.W_CHAN(W_CHAN), .N_CHAN(N_CHAN), .W_ADDR(W_ADDR), .CLK_DIV(2)) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .bus            (bus_if),
        .dac_sync_n_out (dac_sync_n),
        .dac_sclk_out   (dac_sclk),
        .dac_din_out    (dac_din),
        .busy_out       (busy),
        .frame_done_out (frame_done),
        .chan_addr_out  (chan_addr),
        .sweep_done_out (sweep_done),
        .overrun_out    (overrun),
        .dbg_state      (dbg_state)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] frame_q[$];
    int          low_q[$];
    logic [31:0] addr_q[$];
    int n_frame_done, n_sweep_done, n_overrun, busy_cycles, busy_rises;
    int idle_viol = 0;
    int din_viol  = 0;
    logic [31:0] shift_w;
    int low_cnt;
    logic prev_sclk, prev_sync_n, prev_din, prev_busy;

    // Pin monitor, sampled on the falling clk edge away from DUT updates.
    always @(negedge clk_in) begin
        if (!rst_n_in) begin
            prev_sclk = 1'b0; prev_sync_n = 1'b1; prev_din = 1'b0; prev_busy = 1'b0;
            low_cnt = 0; shift_w = '0;
        end else begin
            if (!dac_sync_n) begin
                low_cnt++;
                if (prev_sclk && !dac_sclk) shift_w = {shift_w[30:0], dac_din};
                if ((dac_din !== prev_din) && !(dac_sclk && !prev_sclk)) din_viol++;
            end
            if (dac_sync_n && !prev_sync_n) begin
                frame_q.push_back(shift_w);
                low_q.push_back(low_cnt);
                low_cnt = 0;
                shift_w = '0;
            end
            if (dac_sync_n && (dac_sclk || dac_din)) idle_viol++;
            if (frame_done) begin
                n_frame_done++;
                addr_q.push_back(32'(chan_addr));
            end
            if (sweep_done) n_sweep_done++;
            if (overrun) n_overrun++;
            if (busy) busy_cycles++;
            if (busy && !prev_busy) busy_rises++;
            prev_sclk = dac_sclk; prev_sync_n = dac_sync_n; prev_din = dac_din; prev_busy = busy;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] frame_at(input int i);
        if (i < frame_q.size()) return frame_q[i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] low_at(input int i);
        if (i < low_q.size()) return 32'(low_q[i]);
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] addr_at(input int i);
        if (i < addr_q.size()) return addr_q[i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [W_BUS-1:0] chan(input int ch, input logic [15:0] v);
        logic [W_BUS-1:0] d;
        d = '0;
        d[ch*W_CHAN +: W_CHAN] = v;
        return d;
    endfunction

    task automatic clear_mon();
        frame_q.delete(); low_q.delete(); addr_q.delete();
        n_frame_done = 0; n_sweep_done = 0; n_overrun = 0; busy_cycles = 0; busy_rises = 0;
    endtask

    // Present one set for exactly one cycle, then scramble the bus.
    task automatic strobe(input logic [N_CHAN-1:0] mask, input logic [W_BUS-1:0] data);
        @(posedge clk_in); #1;
        bus_if.data_packed = data;
        bus_if.chan_active = mask;
        bus_if.data_valid  = 1'b1;
        @(posedge clk_in); #1;
        bus_if.data_valid  = 1'b0;
        bus_if.data_packed = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus_if.chan_active = N_CHAN'($urandom_range(0, 255));
    endtask

    task automatic wait_sweep(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b1 && n < 20) begin @(posedge clk_in); #2; n++; end
        check({tag, "_busy_rise"}, 32'(busy === 1'b1), 32'd1);
        n = 0;
        while (busy !== 1'b0 && n < 3000) begin @(posedge clk_in); #2; n++; end
        check({tag, "_busy_fall"}, 32'(busy === 1'b0), 32'd1);
        repeat (2) @(posedge clk_in);
        #2;
    endtask

    task automatic after_reset_init();
`ifdef DAC_INIT_EN
        wait_sweep("init");
        check("init_frame_cnt", 32'(frame_q.size()), 32'd1);
        check("init_frame", frame_at(0), 32'h0800_0001);
        check("init_busy", 32'(busy_cycles), 32'd132);
        check("init_frame_done", 32'(n_frame_done), 32'd0);
        check("init_sweep_done", 32'(n_sweep_done), 32'd0);
        clear_mon();
`else
        repeat (2) @(posedge clk_in);
        #2;
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.data_packed = '0;
        bus_if.chan_active = '0;
        bus_if.data_valid  = 1'b0;
        clear_mon();

        // Reset state
        repeat (3) @(posedge clk_in);
        #2;
        check("rst_sync_n", 32'(dac_sync_n), 32'd1);
        check("rst_sclk", 32'(dac_sclk), 32'd0);
        check("rst_din", 32'(dac_din), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_chan_addr", 32'(chan_addr), 32'd0);
        @(negedge clk_in) rst_n_in = 1'b1;
        after_reset_init();

        // Single channel 0, with edge-by-edge start latency
        clear_mon();
        strobe(8'h01, chan(0, 16'hABCD));
        @(negedge clk_in);
        check("t1_busy_edge0", 32'(busy), 32'd0);
        @(negedge clk_in);
        check("t1_busy_edge1", 32'(busy), 32'd1);
        check("t1_sync_edge1", 32'(dac_sync_n), 32'd1);
        @(negedge clk_in);
        check("t1_sync_edge2", 32'(dac_sync_n), 32'd0);
        check("t1_sclk_edge2", 32'(dac_sclk), 32'd1);
        check("t1_din_edge2", 32'(dac_din), 32'd0);
        wait_sweep("t1");
        check("t1_frames", 32'(frame_q.size()), 32'd1);
        check("t1_frame0", frame_at(0), 32'h030A_BCD0);
        check("t1_sync_low", low_at(0), 32'd128);
        check("t1_frame_done", 32'(n_frame_done), 32'd1);
        check("t1_addr0", addr_at(0), 32'd0);
        check("t1_sweep_done", 32'(n_sweep_done), 32'd1);
        check("t1_busy_cycles", 32'(busy_cycles), 32'd133);
        check("t1_overrun", 32'(n_overrun), 32'd0);

        // Sparse mask: channels 2, 5, 7
        clear_mon();
        strobe(8'hA4, chan(2, 16'h1357) | chan(5, 16'h2468) | chan(7, 16'hFFFF) | chan(3, 16'h9999));
        wait_sweep("t2");
        check("t2_frames", 32'(frame_q.size()), 32'd3);
        check("t2_frame0", frame_at(0), 32'h0321_3570);
        check("t2_frame1", frame_at(1), 32'h0352_4680);
        check("t2_frame2", frame_at(2), 32'h037F_FFF0);
        check("t2_addr0", addr_at(0), 32'd2);
        check("t2_addr1", addr_at(1), 32'd5);
        check("t2_addr2", addr_at(2), 32'd7);
        check("t2_frame_done", 32'(n_frame_done), 32'd3);
        check("t2_sweep_done", 32'(n_sweep_done), 32'd1);
        check("t2_busy_cycles", 32'(busy_cycles), 32'd399);

        // Empty mask does nothing
        clear_mon();
        strobe(8'h00, chan(0, 16'h1234));
        repeat (300) @(posedge clk_in);
        #2;
        check("t3_frames", 32'(frame_q.size()), 32'd0);
        check("t3_busy_cycles", 32'(busy_cycles), 32'd0);
        check("t3_pulses", 32'(n_frame_done + n_sweep_done + n_overrun), 32'd0);

        // Two strobes during a sweep: latest wins, one overrun, back-to-back sweep
        clear_mon();
        strobe(8'h01, chan(0, 16'h0001));
        repeat (20) @(posedge clk_in);
        strobe(8'h01, chan(0, 16'h1111));
        repeat (10) @(posedge clk_in);
        strobe(8'h01, chan(0, 16'h2222));
        wait_sweep("t4");
        check("t4_frames", 32'(frame_q.size()), 32'd2);
        check("t4_frame0", frame_at(0), 32'h0300_0010);
        check("t4_frame1", frame_at(1), 32'h0302_2220);
        check("t4_overrun", 32'(n_overrun), 32'd1);
        check("t4_sweep_done", 32'(n_sweep_done), 32'd2);
        check("t4_busy_rises", 32'(busy_rises), 32'd1);
        check("t4_busy_cycles", 32'(busy_cycles), 32'd266);

        // Reset mid-SHIFT with a pending set queued
        clear_mon();
        strobe(8'h01, chan(0, 16'h5A5A));
        repeat (10) @(posedge clk_in);
        strobe(8'h02, chan(1, 16'h7777));
        repeat (30) @(posedge clk_in);
        #3;
        check("t5_pre_sync", 32'(dac_sync_n), 32'd0);
        rst_n_in = 1'b0;
        #1;
        check("t5_rst_sync_n", 32'(dac_sync_n), 32'd1);
        check("t5_rst_sclk", 32'(dac_sclk), 32'd0);
        check("t5_rst_din", 32'(dac_din), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk_in);
        clear_mon();
        @(negedge clk_in) rst_n_in = 1'b1;
        after_reset_init();
        repeat (300) @(posedge clk_in);
        #2;
        check("t5_no_stale_frames", 32'(frame_q.size()), 32'd0);
        check("t5_no_stale_busy", 32'(busy_cycles), 32'd0);
        strobe(8'h01, chan(0, 16'hC3C3));
        wait_sweep("t5");
        check("t5_frames", 32'(frame_q.size()), 32'd1);
        check("t5_frame0", frame_at(0), 32'h030C_3C30);
        check("t5_sync_low", low_at(0), 32'd128);
        check("t5_busy_cycles", 32'(busy_cycles), 32'd133);
        check("t5_addr0", addr_at(0), 32'd0);

        // Pin rules across the whole run
        check("idle_pins", 32'(idle_viol), 32'd0);
        check("din_timing", 32'(din_viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
